// File: rtl/div_unit_if.sv
// Request/response bundle between the EXE-stage pipeline and the iterative divider.
// The pipeline drives the request side through the master modport.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            cancel;
    logic [XLEN-1:0] r;
    logic            busy;
    logic            ready;

    modport master (
        output start, op, a, b, cancel,
        input  r, busy, ready
    );

    modport slave (
        input  start, op, a, b, cancel,
        output r, busy, ready
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a fixed XLEN-cycle CALC phase.
// Signed ops divide magnitudes and fix the signs up when the result is loaded.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic      clk,
    input logic      clrn,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] count_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] r_q;
    logic            rem_op_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            div0_q;
    logic            busy_q;
    logic            ready_q;

    logic            signed_op;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_ext;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] dvd_d;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] result_d;

    // Operand conditioning for the request being sampled in IDLE.
    always_comb begin
        signed_op = ~bus.op[0];
        sa        = signed_op & bus.a[XLEN-1];
        sb        = signed_op & bus.b[XLEN-1];
        a_mag     = sa ? (~bus.a + XLEN'(1)) : bus.a;
        b_mag     = sb ? (~bus.b + XLEN'(1)) : bus.b;
    end

    // One restoring step; the partial remainder is one bit wider so unsigned divisors
    // with the MSB set compare correctly after the shift.
    always_comb begin
        rem_ext = {rem_q, dvd_q[XLEN-1]};
        diff    = rem_ext - {1'b0, dvs_q};
        ge      = ~diff[XLEN];
        rem_d   = ge ? diff[XLEN-1:0] : rem_ext[XLEN-1:0];
        dvd_d   = {dvd_q[XLEN-2:0], ge};
    end

    // Final sign fix-up. Divide-by-zero on the remainder path and the signed overflow case
    // fall out of the magnitude arithmetic; only the divide-by-zero quotient needs forcing.
    always_comb begin
        quo_fix  = q_neg_q ? (~dvd_d + XLEN'(1)) : dvd_d;
        rem_fix  = r_neg_q ? (~rem_d + XLEN'(1)) : rem_d;
        result_d = quo_fix;
        if (rem_op_q) begin
            result_d = rem_fix;
        end else if (div0_q) begin
            result_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= StIdle;
            count_q  <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            r_q      <= '0;
            rem_op_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= StCalc;
                        count_q  <= '0;
                        rem_q    <= '0;
                        dvd_q    <= a_mag;
                        dvs_q    <= b_mag;
                        rem_op_q <= bus.op[1];
                        q_neg_q  <= sa ^ sb;
                        r_neg_q  <= sa;
                        div0_q   <= (bus.b == '0);
                        busy_q   <= 1'b1;
                    end
                end
                StCalc: begin
                    if (bus.cancel) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        rem_q   <= rem_d;
                        dvd_q   <= dvd_d;
                        count_q <= count_q + CntW'(1);
                        if (count_q == CntW'(XLEN - 1)) begin
                            state_q <= StDone;
                            r_q     <= result_d;
                            ready_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Cancel here also lands in IDLE; r has already been loaded.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r     = r_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops against an
// arithmetic reference model.
module tb_div_unit;
    localparam int unsigned XLEN = 32;
    localparam int          LAT  = 33;

    logic clk;
    logic clrn;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            2'b00:   if (b == 0) return '1;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                     else return 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   if (b == 0) return a;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                     else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            5:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at the next edge (T). lat is the number of post-edge samples from T up to
    // and including the ready cycle, or -1 if ready never came. On return the DUT has taken
    // one more edge after ready, so the next call's start lands 34 edges after T.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output logic [31:0] res, output int lat,
                          output int bdrop);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat   = -1;
        bdrop = 0;
        res   = 'x;
        for (int i = 1; i <= 40; i++) begin
            if (!bus.busy) bdrop++;
            if (bus.ready) begin
                lat = i;
                res = bus.r;
                break;
            end
            if (i == inject_at) begin
                bus.op    = 2'b01;
                bus.a     = 32'd5;
                bus.b     = 32'd1;
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
            end else begin
                step();
            end
        end
        step();
    endtask

    logic [31:0] res;
    logic [31:0] prev_r;
    int          lat;
    int          bdrop;
    logic        saw_ready;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        clrn       = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 2'b00;
        bus.a      = '0;
        bus.b      = '0;
        step();
        step();
        check("rst_r", bus.r, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h0);
        clrn = 1'b1;
        step();

        // Basic unsigned op with latency and handshake shape.
        run_op(2'b01, 32'd100, 32'd7, 0, res, lat, bdrop);
        check("divu_r", res, 32'd14);
        check("divu_lat", 32'(lat), 32'(LAT));
        check("divu_busy_held", 32'(bdrop), 32'h0);
        check("divu_ready_drop", 32'(bus.ready), 32'h0);
        check("divu_busy_drop", 32'(bus.busy), 32'h0);
        check("divu_r_held", bus.r, 32'd14);
        run_op(2'b11, 32'd100, 32'd7, 0, res, lat, bdrop);
        check("remu_r", res, 32'd2);

        // Signed sign rules.
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bdrop);
        check("div_neg", res, 32'hFFFF_FFFD);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bdrop);
        check("rem_neg", res, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, res, lat, bdrop);
        check("rem_negb", res, 32'd1);

        // Divide by zero keeps the full latency.
        run_op(2'b01, 32'h1234, 32'h0, 0, res, lat, bdrop);
        check("divu_z", res, 32'hFFFF_FFFF);
        check("divu_z_lat", 32'(lat), 32'(LAT));
        run_op(2'b00, 32'h1234, 32'h0, 0, res, lat, bdrop);
        check("div_z", res, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFF0, 32'h0, 0, res, lat, bdrop);
        check("div_z_neg", res, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h1234, 32'h0, 0, res, lat, bdrop);
        check("rem_z", res, 32'h1234);
        run_op(2'b11, 32'h1234, 32'h0, 0, res, lat, bdrop);
        check("remu_z", res, 32'h1234);

        // Signed overflow.
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, bdrop);
        check("div_ovf", res, 32'h8000_0000);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, bdrop);
        check("rem_ovf", res, 32'h0);

        // Start while busy is ignored.
        run_op(2'b01, 32'd1000, 32'd10, 5, res, lat, bdrop);
        check("inject_r", res, 32'd100);
        check("inject_lat", 32'(lat), 32'(LAT));
        check("inject_idle", 32'(bus.busy), 32'h0);

        // Cancel mid-CALC: no ready, r untouched.
        prev_r    = bus.r;
        bus.op    = 2'b01;
        bus.a     = 32'd999;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("cancel_pre_busy", 32'(bus.busy), 32'h1);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        check("cancel_busy", 32'(bus.busy), 32'h0);
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready) saw_ready = 1'b1;
            step();
        end
        check("cancel_noready", 32'(saw_ready), 32'h0);
        check("cancel_r", bus.r, prev_r);
        run_op(2'b11, 32'd17, 32'd5, 0, res, lat, bdrop);
        check("after_cancel", res, 32'd2);

        // Synchronous reset in the middle of CALC.
        bus.op    = 2'b01;
        bus.a     = 32'd77;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        clrn = 1'b0;
        step();
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_r", bus.r, 32'h0);
        check("mid_rst_ready", 32'(bus.ready), 32'h0);
        clrn = 1'b1;
        step();

        // Randomized back-to-back ops against the model.
        for (int k = 0; k < 800; k++) begin
            rop = 2'(k % 4);
            ra  = rnd_val();
            rb  = rnd_val();
            run_op(rop, ra, rb, 0, res, lat, bdrop);
            check($sformatf("rand op%0d a=%h b=%h", rop, ra, rb), res, model(rop, ra, rb));
            check($sformatf("rand_lat op%0d", rop), 32'(lat), 32'(LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
